// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch front end. Owns the PC, issues sequential ROM reads and
// queues {instr, pc} for Decode. Optional macro FETCH_BYPASS_EN forwards a response directly when empty.
module fetch_buffer #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int          DEPTH    = 4,
    parameter int          ROM_AW   = 10
) (
    input  logic              clock_i,
    input  logic              reset_i,
    output logic [ROM_AW-1:0] rom_address_o,
    output logic              rom_read_o,
    input  logic [31:0]       rom_data_i,
    output logic [31:0]       instr_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_target_i
);
    localparam int            AW      = $clog2(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [AW+1:0] DEPTH_C = (AW+2)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   issue_pc_q, issue_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_pc_q    [DEPTH];

    logic [AW+1:0] occupancy;
    logic          issue, resp, fifo_empty, bypass, push, pop;

    always_comb begin
        // A read in flight already owns a slot, so it counts against the depth.
        occupancy  = {1'b0, count_q} + {{(AW+1){1'b0}}, inflight_q};
        fifo_empty = (count_q == '0);
        issue      = reset_i & ~redirect_i & (occupancy < DEPTH_C);
        resp       = inflight_q & ~redirect_i;
`ifdef FETCH_BYPASS_EN
        bypass     = resp & fifo_empty;
`else
        bypass     = 1'b0;
`endif
        valid_o    = ~fifo_empty | bypass;
        instr_o    = NOP;
        pc_o       = issue_pc_q;
        if (!fifo_empty) begin
            instr_o = mem_instr_q[rd_ptr_q];
            pc_o    = mem_pc_q[rd_ptr_q];
        end
`ifdef FETCH_BYPASS_EN
        else if (bypass) begin
            instr_o = rom_data_i;
            pc_o    = inflight_pc_q;
        end
`endif
        push          = resp & ~(bypass & ready_i);
        pop           = ~fifo_empty & ready_i & ~redirect_i;
        rom_read_o    = issue;
        rom_address_o = fetch_pc_q[ROM_AW+1:2];
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        issue_pc_d    = issue_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = issue;
        if (issue) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            issue_pc_d    = fetch_pc_q;
            inflight_pc_d = fetch_pc_q;
        end
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // Redirect flushes the queue and drops the response arriving this cycle.
        if (redirect_i) begin
            fetch_pc_d = {redirect_target_i[31:2], 2'b00};
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            fetch_pc_q    <= RESET_PC;
            issue_pc_q    <= RESET_PC;
            inflight_pc_q <= RESET_PC;
            inflight_q    <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            issue_pc_q    <= issue_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= rom_data_i;
            mem_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// Testbench for fetch_buffer: ROM model with ROM[k]=k+1 and a stream-level scoreboard
// (expected PC sequence plus outstanding-word count) checked under directed and random traffic.
module tb_fetch_buffer;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 4;
    localparam int          ROM_AW   = 10;
    localparam logic [31:0] NOP      = 32'h0000_0013;
`ifdef FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    function automatic logic [31:0] rom_fn(input logic [9:0] a);
        return 32'(a) + 32'd1;
    endfunction

    logic        clk;
    logic        rst_n;
    logic [9:0]  rom_address;
    logic        rom_read;
    logic [31:0] rom_data;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [9:0]  rom_addr_q;

    fetch_buffer #(.RESET_PC(RESET_PC), .DEPTH(DEPTH), .ROM_AW(ROM_AW)) dut (
        .clock_i(clk), .reset_i(rst_n), .rom_address_o(rom_address), .rom_read_o(rom_read),
        .rom_data_i(rom_data), .instr_o(instr), .pc_o(pc), .valid_o(valid), .ready_i(ready),
        .redirect_i(redirect), .redirect_target_i(redirect_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rom_addr_q <= rom_address;
    assign rom_data = rom_fn(rom_addr_q);

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_pc = RESET_PC;
    logic [31:0] pop_exp_pc;
    int          outstanding = 0;
    int          out_before;
    bit          popped, stall_now, prev_stall;
    logic        obs_valid, obs_rom_read;
    logic [31:0] obs_pc, obs_instr, prev_pc, prev_instr;
    logic [9:0]  obs_addr;

    // One clock: drive inputs after the falling edge, sample, then advance the model.
    task automatic tick(input logic rst, input logic rdy, input logic rdr, input logic [31:0] tgt);
        @(negedge clk);
        rst_n = rst; ready = rdy; redirect = rdr; redirect_target = tgt;
        #1;
        prev_stall = stall_now;
        prev_pc    = obs_pc;
        prev_instr = obs_instr;
        obs_valid = valid; obs_pc = pc; obs_instr = instr;
        obs_rom_read = rom_read; obs_addr = rom_address;
        out_before = outstanding;
        popped = rst && !rdr && rdy && (obs_valid === 1'b1);
        if (popped) begin
            pop_exp_pc = exp_pc;
            exp_pc = exp_pc + 32'd4;
            outstanding--;
        end
        if (!rst) begin
            exp_pc = RESET_PC; outstanding = 0;
        end else if (rdr) begin
            exp_pc = {tgt[31:2], 2'b00}; outstanding = 0;
        end
        if (obs_rom_read === 1'b1) outstanding++;
        stall_now = rst && !rdr && !rdy && (obs_valid === 1'b1);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b1, 1'b1, 32'h80);
        tick(1'b0, 1'b1, 1'b1, 32'h80);
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", obs_valid); end
        checks++;
        if (obs_rom_read !== 1'b0) begin errors++; $display("FAIL reset_rom_read: got %b expected 0", obs_rom_read); end
        checks++;
        if (obs_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", obs_instr, NOP); end
        checks++;
        if (obs_pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", obs_pc, RESET_PC); end
    endtask

    task automatic test_first_fetch();
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (obs_rom_read !== 1'b1 || obs_addr !== RESET_PC[11:2]) begin
            errors++; $display("FAIL first_issue: got read %b addr %h expected read 1 addr %h", obs_rom_read, obs_addr, RESET_PC[11:2]);
        end
        for (int k = 1; k <= LAT; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_valid !== (k == LAT)) begin
                errors++; $display("FAIL first_latency: cycle %0d got valid %b expected %b", k, obs_valid, (k == LAT));
            end
        end
        checks++;
        if (obs_pc !== RESET_PC || obs_instr !== rom_fn(RESET_PC[11:2])) begin
            errors++; $display("FAIL first_word: got pc %h instr %h expected pc %h instr %h", obs_pc, obs_instr, RESET_PC, rom_fn(RESET_PC[11:2]));
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            checks++;
            if (obs_valid !== 1'b1 || obs_pc !== RESET_PC || obs_instr !== rom_fn(RESET_PC[11:2])) begin
                errors++; $display("FAIL stall_hold: got valid %b pc %h instr %h expected 1 %h %h", obs_valid, obs_pc, obs_instr, RESET_PC, rom_fn(RESET_PC[11:2]));
            end
        end
        checks++;
        if (outstanding != DEPTH) begin errors++; $display("FAIL stall_depth: got %0d words expected %0d", outstanding, DEPTH); end
        checks++;
        if (obs_rom_read !== 1'b0) begin errors++; $display("FAIL stall_no_issue: got %b expected 0", obs_rom_read); end
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (!popped || obs_pc !== pop_exp_pc || obs_instr !== rom_fn(pop_exp_pc[11:2])) begin
                errors++; $display("FAIL drain_order: cycle %0d got valid %b pc %h instr %h expected pc %h instr %h", k, obs_valid, obs_pc, obs_instr, pop_exp_pc, rom_fn(pop_exp_pc[11:2]));
            end
        end
    endtask

    task automatic test_stream();
        logic [9:0] last_addr;
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        last_addr = obs_addr;
        for (int k = 0; k < 20; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (!popped || obs_pc !== pop_exp_pc || obs_instr !== rom_fn(pop_exp_pc[11:2])) begin
                errors++; $display("FAIL stream_pop: got valid %b pc %h instr %h expected pc %h", obs_valid, obs_pc, obs_instr, pop_exp_pc);
            end
            checks++;
            if (obs_rom_read !== 1'b1 || obs_addr !== last_addr + 10'd1) begin
                errors++; $display("FAIL stream_issue: got read %b addr %h expected read 1 addr %h", obs_rom_read, obs_addr, last_addr + 10'd1);
            end
            last_addr = obs_addr;
        end
    endtask

    task automatic test_redirect_inflight();
        int n;
        tick(1'b1, 1'b1, 1'b1, 32'h200);
        checks++;
        if (obs_rom_read !== 1'b0) begin errors++; $display("FAIL redirect_no_issue: got %b expected 0", obs_rom_read); end
        n = 0;
        while (outstanding < DEPTH && n < 10) begin
            tick(1'b1, 1'b0, 1'b0, 32'h0);
            n++;
        end
        checks++;
        if (outstanding != DEPTH || obs_valid !== 1'b1 || obs_pc !== 32'h200) begin
            errors++; $display("FAIL redirect_fill: got %0d words valid %b pc %h expected %0d words pc 200", outstanding, obs_valid, obs_pc, DEPTH);
        end
        tick(1'b1, 1'b0, 1'b1, 32'h40);
        tick(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (obs_valid !== 1'b0) begin errors++; $display("FAIL redirect_flush: got valid %b expected 0", obs_valid); end
        n = 0;
        do begin tick(1'b1, 1'b1, 1'b0, 32'h0); n++; end while (!popped && n < 6);
        checks++;
        if (!popped || obs_pc !== 32'h40 || obs_instr !== rom_fn(10'd16)) begin
            errors++; $display("FAIL redirect_first: got valid %b pc %h instr %h expected pc 40 instr %h", obs_valid, obs_pc, obs_instr, rom_fn(10'd16));
        end
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            checks++;
            if (!popped || obs_pc !== pop_exp_pc || obs_instr !== rom_fn(pop_exp_pc[11:2])) begin
                errors++; $display("FAIL redirect_follow: got pc %h instr %h expected pc %h", obs_pc, obs_instr, pop_exp_pc);
            end
        end
    endtask

    task automatic test_redirect_misaligned();
        int n;
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b1, 32'h43);
        checks++;
        if (obs_valid !== 1'b1 || obs_rom_read !== 1'b0) begin
            errors++; $display("FAIL redirect_pop_cycle: got valid %b read %b expected valid 1 read 0", obs_valid, obs_rom_read);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_rom_read !== 1'b1 || obs_addr !== 10'd16) begin
            errors++; $display("FAIL misaligned_issue: got read %b addr %h expected read 1 addr 010", obs_rom_read, obs_addr);
        end
        n = 0;
        while (!popped && n < 6) begin tick(1'b1, 1'b1, 1'b0, 32'h0); n++; end
        checks++;
        if (!popped || obs_pc !== 32'h40 || obs_instr !== rom_fn(10'd16)) begin
            errors++; $display("FAIL misaligned_first: got valid %b pc %h instr %h expected pc 40", obs_valid, obs_pc, obs_instr);
        end
    endtask

    task automatic test_reset_midstream();
        int n;
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++) tick(1'b1, 1'b0, 1'b0, 32'h0);
        checks++;
        if (obs_valid !== 1'b1) begin errors++; $display("FAIL midreset_prefill: got valid %b expected 1", obs_valid); end
        tick(1'b0, 1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_valid !== 1'b0 || obs_pc !== RESET_PC) begin
            errors++; $display("FAIL midreset_state: got valid %b pc %h expected 0 %h", obs_valid, obs_pc, RESET_PC);
        end
        checks++;
        if (obs_rom_read !== 1'b1 || obs_addr !== RESET_PC[11:2]) begin
            errors++; $display("FAIL midreset_issue: got read %b addr %h expected 1 %h", obs_rom_read, obs_addr, RESET_PC[11:2]);
        end
        n = 0;
        while (!popped && n < 6) begin tick(1'b1, 1'b1, 1'b0, 32'h0); n++; end
        checks++;
        if (!popped || obs_pc !== RESET_PC || obs_instr !== rom_fn(RESET_PC[11:2])) begin
            errors++; $display("FAIL midreset_restart: got pc %h instr %h expected pc %h", obs_pc, obs_instr, RESET_PC);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] seen [$];
        tick(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_rom_read !== 1'b1 || obs_addr !== 10'h3FF) begin
            errors++; $display("FAIL wrap_issue_top: got read %b addr %h expected 1 3ff", obs_rom_read, obs_addr);
        end
        tick(1'b1, 1'b1, 1'b0, 32'h0);
        checks++;
        if (obs_rom_read !== 1'b1 || obs_addr !== 10'h000) begin
            errors++; $display("FAIL wrap_issue_zero: got read %b addr %h expected 1 000", obs_rom_read, obs_addr);
        end
        for (int k = 0; k < 6; k++) begin
            tick(1'b1, 1'b1, 1'b0, 32'h0);
            if (popped) begin
                seen.push_back(obs_pc);
                checks++;
                if (obs_instr !== rom_fn(obs_pc[11:2]) || obs_pc !== pop_exp_pc) begin
                    errors++; $display("FAIL wrap_pop: got pc %h instr %h expected pc %h", obs_pc, obs_instr, pop_exp_pc);
                end
            end
        end
        checks++;
        if (seen.size() < 2 || seen[0] !== 32'hFFFF_FFFC || seen[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_sequence: got %0d pops first %h expected fffffffc then 00000000", seen.size(), (seen.size() > 0) ? seen[0] : 32'hx);
        end
    endtask

    task automatic test_random();
        logic rdy, rdr;
        for (int k = 0; k < 400; k++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rdr = ($urandom_range(0, 24) == 0);
            tick(1'b1, rdy, rdr, $urandom());
            if (popped) begin
                checks++;
                if (obs_pc !== pop_exp_pc || obs_instr !== rom_fn(pop_exp_pc[11:2])) begin
                    errors++; $display("FAIL rand_pop: got pc %h instr %h expected pc %h instr %h", obs_pc, obs_instr, pop_exp_pc, rom_fn(pop_exp_pc[11:2]));
                end
            end
            if (prev_stall) begin
                checks++;
                if (obs_valid !== 1'b1 || obs_pc !== prev_pc || obs_instr !== prev_instr) begin
                    errors++; $display("FAIL rand_hold: got valid %b pc %h instr %h expected 1 %h %h", obs_valid, obs_pc, obs_instr, prev_pc, prev_instr);
                end
            end
            checks++;
            if (obs_rom_read !== (!rdr && out_before < DEPTH)) begin
                errors++; $display("FAIL rand_issue: got read %b expected %b with %0d words", obs_rom_read, (!rdr && out_before < DEPTH), out_before);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        stall_now = 1'b0;
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_stream();
        test_redirect_inflight();
        test_redirect_misaligned();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
